// File: rtl/snake_body_controller.sv
// Snake position keeper: proposes the next head, waits for the collision verdict, then commits a move/grow/death.
// Optional build macro REVERSE_BLOCK_EN: a step whose direction directly reverses the stored heading keeps the old heading.
module snake_body_controller #(
  parameter int MAX_LENGTH = 140,
  parameter int COORD_W    = 4,
  parameter int INIT_X     = 4,
  parameter int INIT_Y     = 5
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          step,
  input  logic [1:0]                    direction,
  input  logic                          ready,
  input  logic                          goodCollision,
  input  logic                          badCollision,
  output logic                          check_req,
  output logic [COORD_W-1:0]            snakeHeadX,
  output logic [COORD_W-1:0]            snakeHeadY,
  output logic [MAX_LENGTH*COORD_W-1:0] snakeArrayX,
  output logic [MAX_LENGTH*COORD_W-1:0] snakeArrayY,
  output logic [COORD_W-1:0]            snakeTailX,
  output logic [COORD_W-1:0]            snakeTailY,
  output logic [7:0]                    length,
  output logic                          grew,
  output logic                          game_over,
  output logic [2:0]                    o_dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_PROPOSE, S_WAIT, S_COMMIT, S_DEAD} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [7:0] MAX_LEN8  = 8'(MAX_LENGTH);

  state_t               r_state;
  logic [1:0]           r_heading;
  logic                 r_grow;
  logic [COORD_W-1:0]   r_prev_x, r_prev_y;
  logic [COORD_W-1:0]   r_bx [MAX_LENGTH];
  logic [COORD_W-1:0]   r_by [MAX_LENGTH];

  logic [1:0]           w_dir_sel;
  logic [COORD_W-1:0]   w_next_x, w_next_y;
  logic [7:0]           w_new_len, w_tail_idx;
  logic [COORD_W-1:0]   w_sx [MAX_LENGTH];
  logic [COORD_W-1:0]   w_sy [MAX_LENGTH];

`ifdef REVERSE_BLOCK_EN
  // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  assign w_dir_sel = ((direction ^ r_heading) == 2'b01) ? r_heading : direction;
`else
  assign w_dir_sel = direction;
`endif

  always_comb begin
    w_next_x = snakeHeadX;
    w_next_y = snakeHeadY;
    case (r_heading)
      DIR_UP:   w_next_y = snakeHeadY - COORD_W'(1);
      DIR_DOWN: w_next_y = snakeHeadY + COORD_W'(1);
      DIR_LEFT: w_next_x = snakeHeadX - COORD_W'(1);
      default:  w_next_x = snakeHeadX + COORD_W'(1);
    endcase
  end

  // A grow at full length saturates and behaves like a plain move.
  assign w_new_len  = (r_grow && (length < MAX_LEN8)) ? length + 8'd1 : length;
  assign w_tail_idx = w_new_len - 8'd2;

  always_comb begin
    w_sx[0] = r_prev_x;
    w_sy[0] = r_prev_y;
    for (int i = 1; i < MAX_LENGTH; i++) begin
      w_sx[i] = r_bx[i-1];
      w_sy[i] = r_by[i-1];
    end
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (i >= int'(w_new_len) - 1) begin
        w_sx[i] = '0;
        w_sy[i] = '0;
      end
    end
  end

  // Entry i of the body occupies bits [i*COORD_W +: COORD_W].
  for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_pack
    assign snakeArrayX[g*COORD_W +: COORD_W] = r_bx[g];
    assign snakeArrayY[g*COORD_W +: COORD_W] = r_by[g];
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state    <= S_IDLE;
      r_heading  <= DIR_RIGHT;
      r_grow     <= 1'b0;
      r_prev_x   <= COORD_W'(INIT_X);
      r_prev_y   <= COORD_W'(INIT_Y);
      snakeHeadX <= COORD_W'(INIT_X);
      snakeHeadY <= COORD_W'(INIT_Y);
      snakeTailX <= COORD_W'(INIT_X - 2);
      snakeTailY <= COORD_W'(INIT_Y);
      length     <= 8'd3;
      check_req  <= 1'b0;
      grew       <= 1'b0;
      game_over  <= 1'b0;
      for (int i = 0; i < MAX_LENGTH; i++) begin
        r_bx[i] <= '0;
        r_by[i] <= '0;
      end
      r_bx[0] <= COORD_W'(INIT_X - 1);
      r_by[0] <= COORD_W'(INIT_Y);
      r_bx[1] <= COORD_W'(INIT_X - 2);
      r_by[1] <= COORD_W'(INIT_Y);
    end else begin
      grew <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (step) begin
            r_heading <= w_dir_sel;
            check_req <= 1'b1;
            r_state   <= S_PROPOSE;
          end
        end
        S_PROPOSE: begin
          r_prev_x   <= snakeHeadX;
          r_prev_y   <= snakeHeadY;
          snakeHeadX <= w_next_x;
          snakeHeadY <= w_next_y;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (ready) begin
            check_req <= 1'b0;
            if (badCollision) begin
              game_over  <= 1'b1;
              snakeHeadX <= r_prev_x;
              snakeHeadY <= r_prev_y;
              r_state    <= S_DEAD;
            end else begin
              r_grow  <= goodCollision;
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < MAX_LENGTH; i++) begin
            r_bx[i] <= w_sx[i];
            r_by[i] <= w_sy[i];
          end
          length     <= w_new_len;
          snakeTailX <= w_sx[w_tail_idx];
          snakeTailY <= w_sy[w_tail_idx];
          grew       <= r_grow;
          r_state    <= S_IDLE;
        end
        S_DEAD: begin
          check_req <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_controller.sv
// Directed bench for snake_body_controller: driver issues moves and queues the expected post-move snapshot,
// a monitor compares each snapshot one cycle after check_req drops.
module tb_snake_body_controller;

  localparam int ML = 140;
  localparam int CW = 4;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  logic                clk, nrst, step, ready, good_c, bad_c;
  logic [1:0]          direction;
  logic                check_req, grew, game_over;
  logic [CW-1:0]       head_x, head_y, tail_x, tail_y;
  logic [ML*CW-1:0]    arr_x, arr_y;
  logic [7:0]          length;
  logic [2:0]          dbg_state;

  logic [49:0]         exp_q[$];
  logic [7:0]          body_q[$];
  int                  n_tests = 0;
  int                  n_fail  = 0;

  snake_body_controller dut (
    .clk(clk), .nrst(nrst), .step(step), .direction(direction), .ready(ready),
    .goodCollision(good_c), .badCollision(bad_c), .check_req(check_req),
    .snakeHeadX(head_x), .snakeHeadY(head_y), .snakeArrayX(arr_x), .snakeArrayY(arr_y),
    .snakeTailX(tail_x), .snakeTailY(tail_y), .length(length), .grew(grew),
    .game_over(game_over), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [49:0] pack(input logic [3:0] hx, hy, e0x, e0y, e1x, e1y, e2x, e2y, tx, ty,
                                       input logic [7:0] len, input logic gr, go);
    return {hx, hy, e0x, e0y, e1x, e1y, e2x, e2y, tx, ty, len, gr, go};
  endfunction

  function automatic logic [49:0] cur_vec();
    return pack(head_x, head_y, arr_x[3:0], arr_y[3:0], arr_x[7:4], arr_y[7:4],
                arr_x[11:8], arr_y[11:8], tail_x, tail_y, length, grew, game_over);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    nrst = 1'b1;
    step = 1'b0; ready = 1'b0; good_c = 1'b0; bad_c = 1'b0; direction = RIGHT;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] dir);
    @(posedge clk); #1;
    step = 1'b1; direction = dir;
    @(posedge clk); #1;
    step = 1'b0;
    chk("check_req_after_step", check_req, 1);
  endtask

  task automatic do_ready(input int nhold, input logic good, bad, step_in_wait);
    @(posedge clk); #1;
    for (int i = 0; i < nhold; i++) begin
      step = step_in_wait && (i == 0);
      @(posedge clk); #1;
      chk("check_req_hold", check_req, 1);
    end
    step = 1'b0; ready = 1'b1; good_c = good; bad_c = bad;
    @(posedge clk); #1;
    ready = 1'b0; good_c = 1'b0; bad_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic        prev;
    logic [49:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        prev = 1'b0;
      end else if (prev && !check_req) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", cur_vec(), 50'h0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_snapshot", cur_vec(), e);
          if (e[1] && !nrst) begin
            @(negedge clk);
            chk("grew_single_pulse", grew, 0);
          end
        end
        prev = check_req;
      end else begin
        prev = check_req;
      end
    end
  end

  localparam logic [49:0] RESET_VEC = 50'({4'd4, 4'd5, 4'd3, 4'd5, 4'd2, 4'd5, 4'd0, 4'd0, 4'd2, 4'd5, 8'd3, 1'b0, 1'b0});

  initial begin
    logic [3:0] mhx, mhy;
    logic [7:0] mlen, e2;

    apply_reset();
    chk("reset_state", cur_vec(), RESET_VEC);
    chk("reset_check_req", check_req, 0);
    chk("reset_entry139", arr_x[139*CW +: CW], 0);

    // plain move right with a delayed verdict
    exp_q.push_back(pack(5, 5, 4, 5, 3, 5, 0, 0, 3, 5, 3, 0, 0));
    do_step(RIGHT);
    do_ready(3, 0, 0, 0);

    // grow upward, then plain move right, then death with both flags
    apply_reset();
    exp_q.push_back(pack(4, 4, 4, 5, 3, 5, 2, 5, 2, 5, 4, 1, 0));
    do_step(UP);
    do_ready(1, 1, 0, 0);
    exp_q.push_back(pack(5, 4, 4, 4, 4, 5, 3, 5, 3, 5, 4, 0, 0));
    do_step(RIGHT);
    do_ready(0, 0, 0, 0);
    chk("entry3_cleared", {arr_x[15:12], arr_y[15:12]}, 0);
    exp_q.push_back(pack(5, 4, 4, 4, 4, 5, 3, 5, 3, 5, 4, 0, 1));
    do_step(DOWN);
    do_ready(2, 1, 1, 0);
    @(posedge clk); #1 step = 1'b1; direction = LEFT;
    @(posedge clk); #1 step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dead_no_check_req", check_req, 0);
      @(posedge clk); #1;
    end
    chk("dead_sticky", game_over, 1);

    // step during WAIT is dropped
    apply_reset();
    exp_q.push_back(pack(4, 6, 4, 5, 3, 5, 0, 0, 3, 5, 3, 0, 0));
    do_step(DOWN);
    do_ready(2, 0, 0, 1);
    repeat (3) begin
      chk("no_second_move", check_req, 0);
      @(posedge clk); #1;
    end

    // asynchronous reset while waiting for a verdict
    apply_reset();
    do_step(RIGHT);
    @(posedge clk); #1;
    chk("proposed_head_visible", {head_x, head_y}, {4'd5, 4'd5});
    #2 nrst = 1'b1;
    #1;
    chk("async_reset_state", cur_vec(), RESET_VEC);
    chk("async_reset_check_req", check_req, 0);
    @(negedge clk);
    @(posedge clk); #1 nrst = 1'b0;

    // reversal against the stored RIGHT heading
    apply_reset();
`ifdef REVERSE_BLOCK_EN
    exp_q.push_back(pack(5, 5, 4, 5, 3, 5, 0, 0, 3, 5, 3, 0, 0));
`else
    exp_q.push_back(pack(3, 5, 4, 5, 3, 5, 0, 0, 3, 5, 3, 0, 0));
`endif
    do_step(LEFT);
    do_ready(0, 0, 0, 0);

    // grow to the length limit and one step past it
    apply_reset();
    mhx = 4'd4; mhy = 4'd5; mlen = 8'd3;
    body_q = '{8'h35, 8'h25};
    for (int k = 0; k < 138; k++) begin
      body_q.push_front({mhx, mhy});
      mhx = mhx + 4'd1;
      if (mlen < 8'd140) mlen = mlen + 8'd1;
      else void'(body_q.pop_back());
      e2 = (body_q.size() > 2) ? body_q[2] : 8'h00;
      exp_q.push_back(pack(mhx, mhy, body_q[0][7:4], body_q[0][3:0], body_q[1][7:4], body_q[1][3:0],
                           e2[7:4], e2[3:0], body_q[body_q.size()-1][7:4], body_q[body_q.size()-1][3:0],
                           mlen, 1'b1, 1'b0));
      do_step(RIGHT);
      do_ready(0, 1, 0, 0);
    end
    chk("sat_length", length, 140);
    chk("sat_entry139_zero", {arr_x[139*CW +: CW], arr_y[139*CW +: CW]}, 0);
    chk("sat_entry138_is_tail", {arr_x[138*CW +: CW], arr_y[138*CW +: CW]}, {tail_x, tail_y});

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
